// File: rtl/p2p_pkg.sv
// Shared types and constants for the point-to-point multiply scheduler.
package p2p_pkg;

  localparam int NREQ_DEF   = 2;
  localparam int SIZE_DEF   = 16;
  localparam int DATA_W_DEF = 8;

  // Width of a requester index. It is never narrower than 1 bit, so a port
  // that carries the index always exists.
  function automatic int id_width(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  localparam int ID_W_DEF = id_width(NREQ_DEF);

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    LOAD,
    COMPUTE,
    FIN
  } state_t;

  // Engine contract:
  //  - eng_rst (sync, active high) clears the operand index and the done flag.
  //  - Each cycle with eng_start high is one engine step. eng_start low freezes the engine.
  //  - Steps 0..SIZE-1 load operands. The next step switches the engine to read mode.
  //  - Every later step writes a[k]*coef[k] (truncated) into eng_cout.
  //  - eng_done rises together with the final product.
  localparam int ENG_SWITCH_STEPS = 1;
  // A product lands in eng_cout one cycle after its step, so the first product
  // is visible this many COMPUTE cycles after the COMPUTE state is entered.
  localparam int EMIT_LAG         = ENG_SWITCH_STEPS + 1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request at or after ptr.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int ID_W = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] gnt_idx,
  output logic            any
);

  // Walk the requests starting at ptr and wrapping around. The first hit wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!any && req[(int'(ptr) + i) % NREQ]) begin
        any                          = 1'b1;
        gnt[(int'(ptr) + i) % NREQ]  = 1'b1;
        gnt_idx                      = ID_W'((int'(ptr) + i) % NREQ);
      end
    end
  end

endmodule

// File: rtl/p2p_mult_scheduler.sv
// Shares one point-to-point multiply engine between NREQ requesters. Jobs are
// granted round-robin, and the scheduler sequences the engine through its
// clear, load and compute phases, returning tagged products.
module p2p_mult_scheduler
  import p2p_pkg::*;
#(
  parameter int  NREQ   = NREQ_DEF,
  parameter int  SIZE   = SIZE_DEF,
  parameter int  DATA_W = DATA_W_DEF,
  localparam int ID_W   = id_width(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_job,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        job_done,
  output logic                   res_valid,
  output logic [DATA_W-1:0]      res_data,
  output logic [ID_W-1:0]        res_id,
  output logic                   res_last,
  output logic                   busy,
  output logic                   eng_rst,
  output logic                   eng_start,
  output logic [DATA_W-1:0]      eng_a_in,
  input  logic                   eng_done,
  input  logic [DATA_W-1:0]      eng_cout
);

  // The counter is wide enough for the beat index in LOAD and for the step
  // index in COMPUTE, which runs up to SIZE+EMIT_LAG-1.
  localparam int CNT_W = $clog2(SIZE + EMIT_LAG) + 1;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   gnt_id;
  logic [NREQ-1:0]   gnt_oh;
  logic [CNT_W-1:0]  cnt;

  logic [NREQ-1:0]   arb_gnt;
  logic [ID_W-1:0]   arb_idx;
  logic              arb_any;

  logic              beat;
  logic              beat_last;
  logic              emit;
  logic [CNT_W-1:0]  prod_idx;
  logic              prod_last;

  rr_arbiter #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_arb (
    .req     (req_job),
    .ptr     (rr_ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  assign beat      = (state == LOAD) && req_valid[gnt_id];
  assign beat_last = (cnt == CNT_W'(SIZE - 1));
  // The first COMPUTE step is the engine mode switch. Products trail their step by one cycle.
  assign emit      = (state == COMPUTE) && (cnt >= CNT_W'(EMIT_LAG));
  assign prod_idx  = cnt - CNT_W'(EMIT_LAG);
  assign prod_last = (prod_idx == CNT_W'(SIZE - 1));

  // State, grant latch, beat/step counter and round-robin pointer.
  // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      gnt_id <= '0;
      gnt_oh <= '0;
      cnt    <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (arb_any) begin
            gnt_id <= arb_idx;
            gnt_oh <= arb_gnt;
          end
        end
        CLR:     cnt <= '0;
        LOAD: begin
          if (beat) cnt <= beat_last ? '0 : cnt + 1'b1;
        end
        COMPUTE: cnt <= (emit && prod_last) ? '0 : cnt + 1'b1;
        FIN:     rr_ptr <= (gnt_id == ID_W'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
        default: ;
      endcase
    end
  end

  // Next-state and all outputs decoded from the current state.
  // NOTE: every output gets a default first, so no path through the case can infer a latch.
  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    eng_rst   = 1'b0;
    eng_start = 1'b0;
    eng_a_in  = '0;
    req_ready = '0;
    job_done  = '0;
    res_valid = 1'b0;
    res_data  = '0;
    res_id    = '0;
    res_last  = 1'b0;
    unique case (state)
      IDLE: begin
        busy    = 1'b0;
        eng_rst = 1'b1;
        if (arb_any) state_nxt = CLR;
      end
      CLR: begin
        eng_rst   = 1'b1;
        state_nxt = LOAD;
      end
      LOAD: begin
        req_ready = gnt_oh;
        eng_a_in  = req_data[gnt_id*DATA_W +: DATA_W];
        eng_start = req_valid[gnt_id];
        if (beat && beat_last) state_nxt = COMPUTE;
      end
      COMPUTE: begin
        eng_start = 1'b1;
        if (emit) begin
          res_valid = 1'b1;
          res_data  = eng_cout;
          res_id    = gnt_id;
          res_last  = prod_last;
          if (prod_last) state_nxt = FIN;
        end
      end
      FIN: begin
        job_done  = gnt_oh;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The engine must not report done before the last product has been emitted.
  a_early_done : assert property (@(posedge clk) disable iff (!rst)
    (state == COMPUTE && eng_done) |-> (emit && prod_last))
    else $error("engine done before final product");

endmodule

// File: tb/tb_p2p_mult_scheduler.sv
// Self-checking bench for p2p_mult_scheduler. It contains a behavioural engine
// with coef[k]=k+1. A scoreboard queue receives expected products at grant
// time, and a negedge monitor pops and compares them.
module tb_p2p_mult_scheduler;
  import p2p_pkg::*;

  localparam int NREQ    = 2;
  localparam int SIZE    = 16;
  localparam int DATA_W  = 8;
  localparam int ID_W    = 1;
  localparam int JOB_LEN = 2 * SIZE + 4;  // busy cycles, CLR through FIN inclusive

  typedef struct {
    logic [DATA_W-1:0] data;
    int                id;
    bit                last;
  } exp_t;

  typedef struct {
    int id;
    int len;
  } jd_t;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req_job, req_valid, req_ready, job_done;
  logic [NREQ*DATA_W-1:0] req_data;
  logic                   res_valid, res_last, busy;
  logic [DATA_W-1:0]      res_data;
  logic [ID_W-1:0]        res_id;
  logic                   eng_rst, eng_start, eng_done;
  logic [DATA_W-1:0]      eng_a_in, eng_cout;

  logic                   tb_job   [NREQ];
  logic                   tb_valid [NREQ];
  logic [DATA_W-1:0]      tb_data  [NREQ];

  exp_t sb_q[$];
  jd_t  jd_q[$];
  int   grant_log[$];

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_res    = 0;
  int   n_jd     = 0;
  int   busy_cnt = 0;
  logic [DATA_W-1:0] last_res_data;

  bit   intr_seen;
  int   intr_bad;

  for (genvar g = 0; g < NREQ; g++) begin : g_drv
    assign req_job[g]                   = tb_job[g];
    assign req_valid[g]                 = tb_valid[g];
    assign req_data[g*DATA_W +: DATA_W] = tb_data[g];
  end

  always #5 clk = ~clk;

  p2p_mult_scheduler #(
    .NREQ   (NREQ),
    .SIZE   (SIZE),
    .DATA_W (DATA_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_job   (req_job),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .job_done  (job_done),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_id    (res_id),
    .res_last  (res_last),
    .busy      (busy),
    .eng_rst   (eng_rst),
    .eng_start (eng_start),
    .eng_a_in  (eng_a_in),
    .eng_done  (eng_done),
    .eng_cout  (eng_cout)
  );

  // Behavioural engine: SIZE load steps, one mode-switch step, then SIZE product steps.
  // NOTE: the operand store has no reset. Every slot is written before it is read.
  logic [DATA_W-1:0] eng_mem [SIZE];
  int                eng_k;
  logic              eng_rd;
  always @(posedge clk) begin
    if (eng_rst) begin
      eng_k    <= 0;
      eng_rd   <= 1'b0;
      eng_cout <= '0;
      eng_done <= 1'b0;
    end else if (eng_start) begin
      if (!eng_rd) begin
        if (eng_k < SIZE) begin
          eng_mem[eng_k] <= eng_a_in;
          eng_k          <= eng_k + 1;
        end else begin
          eng_rd <= 1'b1;
          eng_k  <= 0;
        end
      end else if (eng_k < SIZE) begin
        eng_cout <= DATA_W'(int'(eng_mem[eng_k]) * (eng_k + 1));
        eng_k    <= eng_k + 1;
        if (eng_k == SIZE - 1) eng_done <= 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int op_val(input int mode, input int k);
    case (mode)
      0:       return 2;
      1:       return 255;
      default: return k + 3;
    endcase
  endfunction

  // Monitor: product scoreboard, job_done ordering and per-job busy length.
  always @(negedge clk) begin
    exp_t e;
    jd_t  j;
    if (!rst) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (res_valid) begin
        n_res++;
        last_res_data = res_data;
        check("res_no_x", 32'($isunknown({res_data, res_id, res_last})), 0);
        if (sb_q.size() == 0) begin
          check("res_unexpected", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("res_data", 32'(res_data), 32'(e.data));
          check("res_id", 32'(res_id), 32'(e.id));
          check("res_last", 32'(res_last), 32'(e.last));
        end
      end
      if (job_done != '0) begin
        n_jd++;
        if (jd_q.size() == 0) begin
          check("job_done_unexpected", 32'(job_done), 0);
        end else begin
          j = jd_q.pop_front();
          check("job_done_id", 32'(job_done), 32'(1) << j.id);
          check("job_len", busy_cnt, j.len);
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_eng_rst"},   32'(eng_rst),   1);
    check({tag, "_busy"},      32'(busy),      0);
    check({tag, "_eng_start"}, 32'(eng_start), 0);
    check({tag, "_res_valid"}, 32'(res_valid), 0);
    check({tag, "_res_last"},  32'(res_last),  0);
    check({tag, "_res_data"},  32'(res_data),  0);
    check({tag, "_res_id"},    32'(res_id),    0);
    check({tag, "_req_ready"}, 32'(req_ready), 0);
    check({tag, "_job_done"},  32'(job_done),  0);
    check({tag, "_eng_a_in"},  32'(eng_a_in),  0);
  endtask

  task automatic clear_drivers();
    for (int i = 0; i < NREQ; i++) begin
      tb_job[i]   = 1'b0;
      tb_valid[i] = 1'b0;
      tb_data[i]  = '0;
    end
  endtask

  // Raise req_job, wait for the grant, queue the expected results, then stream
  // SIZE operands. With bubbles set, every beat is preceded by one idle cycle.
  task automatic do_load(input int id, input int mode, input bit bubbles);
    bit   got = 0;
    bit   bub;
    int   k;
    int   guard;
    exp_t e;
    jd_t  j;
    tb_job[id] = 1'b1;
    for (int g = 0; g < 400 && !got; g++) begin
      @(posedge clk); #1;
      if (req_ready[id]) got = 1;
    end
    check("grant_seen", 32'(got), 1);
    if (!got) return;
    grant_log.push_back(id);
    for (int i = 0; i < SIZE; i++) begin
      e.data = DATA_W'(op_val(mode, i) * (i + 1));
      e.id   = id;
      e.last = (i == SIZE - 1);
      sb_q.push_back(e);
    end
    j.id  = id;
    j.len = JOB_LEN + (bubbles ? SIZE : 0);
    jd_q.push_back(j);
    k     = 0;
    bub   = bubbles;
    guard = 0;
    while (k < SIZE && guard < 4 * SIZE) begin
      if (bub) begin
        tb_valid[id] = 1'b0;
        tb_data[id]  = 8'hC3;
      end else begin
        tb_valid[id] = 1'b1;
        tb_data[id]  = DATA_W'(op_val(mode, k));
      end
      @(posedge clk); #1;
      if (!bub) k++;
      if (bubbles) bub = !bub;
      guard++;
    end
    tb_valid[id] = 1'b0;
  endtask

  task automatic wait_done(input int id, input bit hold);
    bit got = 0;
    for (int g = 0; g < 200 && !got; g++) begin
      @(posedge clk); #1;
      if (job_done[id]) got = 1;
    end
    check("done_seen", 32'(got), 1);
    if (!hold) tb_job[id] = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    clear_drivers();
    sb_q.delete();
    jd_q.delete();
    grant_log.delete();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int jd0;
    bit hit;
    rst = 1'b0;
    clear_drivers();
    apply_reset();

    // 1: single bubble-free job from req0, a[k]=2 -> 2,4,..,32
    do_load(0, 0, 1'b0);
    wait_done(0, 1'b0);
    check("s1_p15", 32'(last_res_data), 32'h20);

    // 3: bubbles on every other cycle; same products, 16 extra busy cycles
    do_load(0, 0, 1'b1);
    wait_done(0, 1'b0);
    check("s3_p15", 32'(last_res_data), 32'h20);

    // 4 + 6: req1 with a[k]=FF while req0 drives stray beats without a job
    intr_seen = 1'b0;
    intr_bad  = 0;
    fork
      begin
        do_load(1, 1, 1'b0);
        wait_done(1, 1'b0);
      end
      begin
        for (int g = 0; g < 100 && !intr_seen; g++) begin
          @(posedge clk); #1;
          intr_seen = req_ready[1];
        end
        for (int c = 0; c < SIZE; c++) begin
          tb_valid[0] = c[0];
          tb_data[0]  = 8'h55;
          if (req_ready[0]) intr_bad++;
          @(posedge clk); #1;
        end
        tb_valid[0] = 1'b0;
        check("s6_nongrant_ready", intr_bad, 0);
      end
    join
    check("s4_p15_trunc", 32'(last_res_data), 32'hF0);

    // 5: reset while product 5 would be presented, then a normal job
    n0 = n_res;
    do_load(0, 0, 1'b0);
    hit = 0;
    for (int g = 0; g < 60 && !hit; g++) begin
      @(posedge clk); #1;
      if (n_res >= n0 + 5) hit = 1;
    end
    check("s5_reached_p5", 32'(hit), 1);
    #1 rst = 1'b0;
    #1 check_reset_outputs("s5");
    sb_q.delete();
    jd_q.delete();
    tb_job[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    jd0 = n_jd;
    repeat (40) @(posedge clk);
    #1;
    check("s5_no_job_done", n_jd - jd0, 0);
    check("s5_idle", 32'(busy), 0);
    do_load(0, 0, 1'b0);
    wait_done(0, 1'b0);
    check("s5_rerun_p15", 32'(last_res_data), 32'h20);

    // 2: simultaneous requests after reset, both held -> 0,1,0,1
    apply_reset();
    fork
      begin
        do_load(0, 0, 1'b0);
        wait_done(0, 1'b1);
        do_load(0, 2, 1'b0);
        wait_done(0, 1'b0);
      end
      begin
        do_load(1, 2, 1'b0);
        wait_done(1, 1'b1);
        do_load(1, 0, 1'b0);
        wait_done(1, 1'b0);
      end
    join
    check("s2_grants", grant_log.size(), 4);
    if (grant_log.size() == 4) begin
      check("s2_g0", grant_log[0], 0);
      check("s2_g1", grant_log[1], 1);
      check("s2_g2", grant_log[2], 0);
      check("s2_g3", grant_log[3], 1);
    end

    repeat (5) @(posedge clk);
    #1;
    check("sb_drained", sb_q.size(), 0);
    check("jd_drained", jd_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
